// File: rtl/generador_paso_auto_pkg.sv
// Shared types and constants for the parking-lot passage generator.
// Holds the FSM state enum, direction codes and per-phase {a,b} sensor patterns.
package paquete_estacionamiento;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_GAP  = 3'd4,
    ST_REV  = 3'd5
  } estado_t;

  localparam logic DIR_ENTRA = 1'b0;
  localparam logic DIR_SALE  = 1'b1;

  localparam logic [1:0] PAT_ENTRA_P1 = 2'b10;
  localparam logic [1:0] PAT_ENTRA_P2 = 2'b11;
  localparam logic [1:0] PAT_ENTRA_P3 = 2'b01;
  localparam logic [1:0] PAT_SALE_P1  = 2'b01;
  localparam logic [1:0] PAT_SALE_P2  = 2'b11;
  localparam logic [1:0] PAT_SALE_P3  = 2'b10;
  localparam logic [1:0] PAT_LIBRE    = 2'b00;

  // REV replays the P1 pattern: the car backs out over the sensor it first tripped.
  function automatic logic [1:0] patron(input logic dir, input estado_t est);
    logic [1:0] p;
    p = PAT_LIBRE;
    case (est)
      ST_P1, ST_REV: p = (dir == DIR_SALE) ? PAT_SALE_P1 : PAT_ENTRA_P1;
      ST_P2:         p = (dir == DIR_SALE) ? PAT_SALE_P2 : PAT_ENTRA_P2;
      ST_P3:         p = (dir == DIR_SALE) ? PAT_SALE_P3 : PAT_ENTRA_P3;
      default:       p = PAT_LIBRE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/generador_paso_auto_temporizador_fase.sv
// Phase dwell down-counter: load a length, count down, expire in the last cycle.
// A loaded value N produces expire in the Nth cycle after the load.
module temporizador_fase (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] valor,
  output logic        expire
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (load) begin
      cnt <= valor;
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign expire = (cnt == 16'd1);

endmodule

// File: rtl/generador_paso_auto.sv
// Car passage generator: emulates sensor pairs a/b for enter/exit passages and models occupancy.
// Optional macro GEN_ABORT_EN adds cmd_abort (car backs out during P2 via the REV state).
module generador_paso_auto
  import paquete_estacionamiento::*;
#(
  parameter int DWELL = 4,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_dir,
`ifdef GEN_ABORT_EN
  input  logic       cmd_abort,
`endif
  output logic       cmd_ready,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [2:0] ocupacion,
  output estado_t    state_dbg
);

  // Handshake: a command is taken in the cycle cmd_valid && cmd_ready; cmd_ready is
  // high only in IDLE and there is no queueing, so cmd_valid while busy is simply ignored.

  localparam logic [15:0] DWELL_V = 16'(DWELL);
  localparam logic [15:0] GAP_V   = 16'(GAP);

  estado_t     state, state_n;
  logic        dir, dir_n;
  logic        load;
  logic [15:0] load_val;
  logic        expire;
  logic        fin;
  logic        abort_now;

  temporizador_fase u_temporizador (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .valor  (load_val),
    .expire (expire)
  );

`ifdef GEN_ABORT_EN
  // Remember an abort seen anywhere inside P2 until that dwell ends.
  logic abort_pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_pend <= 1'b0;
    end else if (state == ST_P2 && !expire) begin
      abort_pend <= abort_pend | cmd_abort;
    end else begin
      abort_pend <= 1'b0;
    end
  end
  assign abort_now = abort_pend | cmd_abort;
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = DWELL_V;
    fin      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_n = ST_P1;
          load    = 1'b1;
        end
      end
      ST_P1: begin
        if (expire) begin
          state_n = ST_P2;
          load    = 1'b1;
        end
      end
      ST_P2: begin
        if (expire) begin
          state_n = abort_now ? ST_REV : ST_P3;
          load    = 1'b1;
        end
      end
      ST_P3, ST_REV: begin
        if (expire) begin
          fin = (state == ST_P3);
          if (GAP == 0) begin
            state_n = ST_IDLE;
          end else begin
            state_n  = ST_GAP;
            load     = 1'b1;
            load_val = GAP_V;
          end
        end
      end
      ST_GAP: begin
        if (expire) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign dir_n = (state == ST_IDLE) ? cmd_dir : dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir       <= DIR_ENTRA;
      a         <= 1'b0;
      b         <= 1'b0;
      done      <= 1'b0;
      ocupacion <= 3'd0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      {a, b}   <= patron(dir_n, state_n);
      done     <= fin;
      if (fin) begin
        if (dir == DIR_ENTRA) begin
          if (ocupacion != 3'd7) ocupacion <= ocupacion + 3'd1;
        end else if (ocupacion != 3'd0) begin
          ocupacion <= ocupacion - 3'd1;
        end
      end
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule
